// File: rtl/stim_sequencer_pkg.sv
// stim_sequencer_pkg
//   Shared definitions for the stimulus sequencer:
//   - state_t     : playback FSM states (IDLE, PLAY, FINISH)
//   - NUM_STEPS   : number of entries in the constant step table
//   - step_vec()  : {i1,i2,i3,i4} vector of a table step
//   - step_dwell(): dwell of a table step in clock cycles
package stim_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int NUM_STEPS = 12;

  // Stimulus vector per step, bit order {i1,i2,i3,i4}.
  function automatic logic [3:0] step_vec(input int idx);
    logic [3:0] v;
    case (idx)
      0:       v = 4'b0010;
      1:       v = 4'b1001;
      2:       v = 4'b1000;
      3:       v = 4'b0010;
      4:       v = 4'b0110;
      5:       v = 4'b1000;
      6:       v = 4'b1001;
      7:       v = 4'b1000;
      8:       v = 4'b0001;
      9:       v = 4'b0011;
      10:      v = 4'b1010;
      11:      v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Dwell per step in cycles.
  function automatic logic [7:0] step_dwell(input int idx);
    logic [7:0] d;
    case (idx)
      0:       d = 8'd2;
      1:       d = 8'd5;
      2:       d = 8'd2;
      3:       d = 8'd4;
      4:       d = 8'd5;
      5:       d = 8'd5;
      6:       d = 8'd5;
      7:       d = 8'd3;
      8:       d = 8'd3;
      9:       d = 8'd2;
      10:      d = 8'd2;
      11:      d = 8'd3;
      default: d = 8'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stim_sequencer_dwell_counter.sv
// dwell_counter
//   Loadable down-counter timing how long the current step is held.
//   Ports:
//     clk, reset : clock, asynchronous active-low reset
//     load       : load `value` (a value of 0 is loaded as 1)
//     value      : dwell in cycles for the step being entered
//     hold       : freeze the count (pause); also masks expire
//     expire     : high during the last cycle of the dwell
module dwell_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         hold,
  output logic         expire
);

  logic [W-1:0] count_q;

  // The count loaded on entry equals the number of cycles the step is shown;
  // the cycle in which it reads 1 is the last one, so the next step can be
  // loaded on that edge without a gap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= (value == '0) ? W'(1) : value;
    end else if (!hold && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = !hold && (count_q == W'(1));

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer
//   Plays a constant table of {i1,i2,i3,i4} vectors, each held for its
//   dwell, into a downstream sequence detector.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     start           : one-cycle playback request, honoured in IDLE only
//     pause           : level; freezes step, vector and dwell in PLAY
//     abort           : one-cycle request to end playback (beats pause/start)
//     i1..i4          : registered stimulus vector
//     step_idx        : index of the step currently driven
//     busy            : high while a step is being driven
//     done            : one-cycle pulse after the last step (LOOP=0 only)
//     dbg_state       : current FSM state, for observation
//   Handshake: start and abort are single-cycle requests sampled on the
//   rising edge; there is no back-pressure. All outputs come from flops.
module stim_sequencer #(
  parameter int NUM_STEPS = stim_sequencer_pkg::NUM_STEPS,
  parameter int DWELL_W   = 16,
  parameter bit LOOP      = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         abort,
  output logic                         i1,
  output logic                         i2,
  output logic                         i3,
  output logic                         i4,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);
  import stim_sequencer_pkg::*;

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic               cnt_hold;
  logic [DWELL_W-1:0] cnt_value;
  logic               cnt_expire;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .value  (cnt_value),
    .hold   (cnt_hold),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic computes the values the output flops take on the next
  // edge, so every output is a register.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_hold  = 1'b1;
    cnt_value = '0;

    case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        vec_d  = '0;
        busy_d = 1'b0;
        if (start && !abort) begin
          state_d   = ST_PLAY;
          vec_d     = step_vec(0);
          busy_d    = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = DWELL_W'(step_dwell(0));
        end
      end

      ST_PLAY: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b0;
        end else if (!pause) begin
          cnt_hold = 1'b0;
          if (cnt_expire) begin
            if (idx_q != LAST_IDX) begin
              idx_d     = idx_q + IDX_W'(1);
              vec_d     = step_vec(int'(idx_q) + 1);
              cnt_load  = 1'b1;
              cnt_value = DWELL_W'(step_dwell(int'(idx_q) + 1));
            end else if (LOOP) begin
              idx_d     = '0;
              vec_d     = step_vec(0);
              cnt_load  = 1'b1;
              cnt_value = DWELL_W'(step_dwell(0));
            end else begin
              state_d = ST_FINISH;
              idx_d   = '0;
              vec_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        vec_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign i1        = vec_q[3];
  assign i2        = vec_q[2];
  assign i3        = vec_q[1];
  assign i4        = vec_q[0];
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer
//   Directed bench: a LOOP=0 instance (dut) and a LOOP=1 instance (dut_l)
//   share clock and reset. Outputs are sampled on the falling edge; inputs
//   are changed right after sampling.
module tb_stim_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start, pause, abort;
  logic i1, i2, i3, i4;
  logic [3:0] step_idx;
  logic busy, done;
  logic [1:0] dbg_state;

  logic start_l, pause_l, abort_l;
  logic j1, j2, j3, j4;
  logic [3:0] step_idx_l;
  logic busy_l, done_l;
  logic [1:0] dbg_state_l;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_vec [12] = '{4'b0010, 4'b1001, 4'b1000, 4'b0010, 4'b0110, 4'b1000,
                               4'b1001, 4'b1000, 4'b0001, 4'b0011, 4'b1010, 4'b1000};
  int exp_dwell [12] = '{2, 5, 2, 4, 5, 5, 5, 3, 3, 2, 2, 3};

  logic [3:0] exp_q[$];
  logic [3:0] exp_idx_q[$];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FINISH = 2'd2;

  always #5 clk = ~clk;

  stim_sequencer #(.NUM_STEPS(12), .DWELL_W(16), .LOOP(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .step_idx(step_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  stim_sequencer #(.NUM_STEPS(12), .DWELL_W(16), .LOOP(1'b1)) dut_l (
    .clk(clk), .reset(reset), .start(start_l), .pause(pause_l), .abort(abort_l),
    .i1(j1), .i2(j2), .i3(j3), .i4(j4), .step_idx(step_idx_l),
    .busy(busy_l), .done(done_l), .dbg_state(dbg_state_l)
  );

  // Fills the scoreboard queues with `reps` passes of the table.
  task automatic fill_queues(input int reps);
    exp_q = {};
    exp_idx_q = {};
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < 12; k++)
        for (int d = 0; d < exp_dwell[k]; d++) begin
          exp_q.push_back(exp_vec[k]);
          exp_idx_q.push_back(4'(k));
        end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 0; pause = 0; abort = 0;
    start_l = 0; pause_l = 0; abort_l = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({i1, i2, i3, i4, step_idx, busy, done} !== 10'd0)
      begin bad++; $display("FAIL reset_outputs: got %b want 0", {i1, i2, i3, i4, step_idx, busy, done}); end
    total++;
    if (dbg_state !== S_IDLE)
      begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    total++;
    if ({j1, j2, j3, j4, step_idx_l, busy_l, done_l} !== 10'd0)
      begin bad++; $display("FAIL reset_outputs_loop: got %b want 0", {j1, j2, j3, j4, step_idx_l, busy_l, done_l}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_nominal();
    logic [3:0] v, e, ei;
    int det;
    det = 0;
    fill_queues(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 41; t++) begin
      v  = {i1, i2, i3, i4};
      e  = exp_q.pop_front();
      ei = exp_idx_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL nominal_vec t=%0d: got %b want %b", t, v, e); end
      total++;
      if (step_idx !== ei) begin bad++; $display("FAIL nominal_idx t=%0d: got %0d want %0d", t, step_idx, ei); end
      total++;
      if (busy !== 1'b1 || done !== 1'b0)
        begin bad++; $display("FAIL nominal_flags t=%0d: got busy=%b done=%b want 1 0", t, busy, done); end
      // Downstream detector: advances on each new table vector in order.
      if (det < 12 && v == exp_vec[det]) det++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || {i1, i2, i3, i4} !== 4'b0000)
      begin bad++; $display("FAIL nominal_done: got done=%b busy=%b vec=%b want 1 0 0000", done, busy, {i1, i2, i3, i4}); end
    total++;
    if (dbg_state !== S_FINISH)
      begin bad++; $display("FAIL nominal_finish_state: got %0d want %0d", dbg_state, S_FINISH); end
    total++;
    if (det !== 12) begin bad++; $display("FAIL detector_final: got %0d want 12", det); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE)
      begin bad++; $display("FAIL nominal_after: got done=%b busy=%b state=%0d want 0 0 0", done, busy, dbg_state); end
  endtask

  task automatic test_pause();
    int k, rem, held, done_t;
    logic p;
    k = 0; rem = exp_dwell[0]; held = 0; done_t = -1;
    // pause high on the start edge must not block the start
    start = 1'b1; pause = 1'b1;
    @(negedge clk);
    start = 1'b0; pause = 1'b0;
    for (int t = 0; t < 60 && done_t < 0; t++) begin
      if (done === 1'b1) begin
        done_t = t;
      end else if (k >= 12) begin
        total++; bad++;
        $display("FAIL pause_done_missing t=%0d: got done=%b want 1", t, done);
      end else begin
        total++;
        if ({i1, i2, i3, i4} !== exp_vec[k] || step_idx !== 4'(k))
          begin bad++; $display("FAIL pause_step t=%0d: got vec=%b idx=%0d want %b %0d", t, {i1, i2, i3, i4}, step_idx, exp_vec[k], k); end
        if ({i1, i2, i3, i4} == 4'b0110) held++;
      end
      p = (t >= 14 && t < 21);
      pause = p;
      if (k < 12 && !p) begin
        rem--;
        if (rem == 0) begin
          k++;
          if (k < 12) rem = exp_dwell[k];
        end
      end
      @(negedge clk);
    end
    pause = 1'b0;
    total++;
    if (done_t !== 48) begin bad++; $display("FAIL pause_done_time: got %0d want 48", done_t); end
    total++;
    if (held !== 12) begin bad++; $display("FAIL pause_hold_len: got %0d want 12", held); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    total++;
    if ({i1, i2, i3, i4} !== 4'b1001 || step_idx !== 4'd6)
      begin bad++; $display("FAIL abort_pre: got vec=%b idx=%0d want 1001 6", {i1, i2, i3, i4}, step_idx); end
    abort = 1'b1; pause = 1'b1;
    @(negedge clk);
    abort = 1'b0; pause = 1'b0;
    total++;
    if ({i1, i2, i3, i4} !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0)
      begin bad++; $display("FAIL abort_clear: got vec=%b busy=%b done=%b idx=%0d want 0000 0 0 0", {i1, i2, i3, i4}, busy, done, step_idx); end
    total++;
    if (dbg_state !== S_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", dbg_state, S_IDLE); end
    for (int t = 0; t < 45; t++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    total++;
    if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      total++;
      if ({i1, i2, i3, i4} !== 4'b0010 || step_idx !== 4'd0 || busy !== 1'b1)
        begin bad++; $display("FAIL abort_restart t=%0d: got vec=%b idx=%0d busy=%b want 0010 0 1", t, {i1, i2, i3, i4}, step_idx, busy); end
      @(negedge clk);
    end
    total++;
    if ({i1, i2, i3, i4} !== 4'b1001 || step_idx !== 4'd1)
      begin bad++; $display("FAIL abort_restart_step1: got vec=%b idx=%0d want 1001 1", {i1, i2, i3, i4}, step_idx); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int active;
    active = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({i1, i2, i3, i4} !== 4'b0010 || step_idx !== 4'd3)
      begin bad++; $display("FAIL areset_pre: got vec=%b idx=%0d want 0010 3", {i1, i2, i3, i4}, step_idx); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({i1, i2, i3, i4, step_idx, busy, done} !== 10'd0 || dbg_state !== S_IDLE)
      begin bad++; $display("FAIL areset_immediate: got %b state=%0d want 0 0", {i1, i2, i3, i4, step_idx, busy, done}, dbg_state); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) active++;
    end
    total++;
    if (active !== 0) begin bad++; $display("FAIL areset_no_resume: got %0d active cycles want 0", active); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE || {i1, i2, i3, i4} !== 4'b0000)
      begin bad++; $display("FAIL start_abort_idle: got busy=%b state=%0d vec=%b want 0 0 0000", busy, dbg_state, {i1, i2, i3, i4}); end
    @(negedge clk);
  endtask

  task automatic test_loop();
    logic [3:0] v, e, ei;
    int done_seen;
    done_seen = 0;
    fill_queues(2);
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    for (int t = 0; t < 50; t++) begin
      v  = {j1, j2, j3, j4};
      e  = exp_q.pop_front();
      ei = exp_idx_q.pop_front();
      total++;
      if (v !== e || step_idx_l !== ei || busy_l !== 1'b1)
        begin bad++; $display("FAIL loop_step t=%0d: got vec=%b idx=%0d busy=%b want %b %0d 1", t, v, step_idx_l, busy_l, e, ei); end
      if (t == 41) begin
        total++;
        if (v !== 4'b0010 || step_idx_l !== 4'd0)
          begin bad++; $display("FAIL loop_wrap: got vec=%b idx=%0d want 0010 0", v, step_idx_l); end
      end
      if (done_l === 1'b1) done_seen++;
      // start while busy must not restart the table
      start_l = (t == 5 || t == 30);
      @(negedge clk);
    end
    start_l = 1'b0;
    total++;
    if (done_seen !== 0) begin bad++; $display("FAIL loop_no_done: got %0d pulses want 0", done_seen); end
    abort_l = 1'b1;
    @(negedge clk);
    abort_l = 1'b0;
    total++;
    if (busy_l !== 1'b0 || {j1, j2, j3, j4} !== 4'b0000)
      begin bad++; $display("FAIL loop_abort: got busy=%b vec=%b want 0 0000", busy_l, {j1, j2, j3, j4}); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pause();
    test_abort();
    test_async_reset();
    test_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 12, number of entries in the step table.
REQ-002 Parameter DWELL_W, default 16, width of the per-step dwell counter.
REQ-003 Parameter LOOP, default 0; when 1, the table replays from step 0 after the last step instead of finishing.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  input  1  one-cycle request to begin playback; honoured only in IDLE.
REQ-007 pause  input  1  level; while 1, outputs and dwell counter hold.
REQ-008 abort  input  1  one-cycle request to end playback immediately.
REQ-009 i1, i2, i3, i4  output  1 each  stimulus vector driven into the downstream sequence detector.
REQ-010 step_idx  output  clog2(NUM_STEPS)  index of the step currently driven.
REQ-011 busy  output  1  high while a step is being driven.
REQ-012 done  output  1  one-cycle pulse after the last step completes.

Function
REQ-013 FSM states shall be IDLE, PLAY and FINISH.
REQ-014 IDLE: i1..i4=0, step_idx=0, busy=0, done=0; start=1 with abort=0 moves to PLAY and loads step 0.
REQ-015 The edge that samples start shall register step 0's vector, so i1..i4 show step 0 from the following cycle.
REQ-016 PLAY: i1..i4 = table vector {i1,i2,i3,i4} of step_idx; busy=1.
REQ-017 Each step shall be held for exactly DWELL[k] cycles (pause-free); a DWELL value of 0 is treated as 1.
REQ-018 On expiry of step k < NUM_STEPS-1, the next cycle drives step k+1 with no gap cycle.
REQ-019 On expiry of the last step: LOOP=0 -> FINISH; LOOP=1 -> step 0 with no gap, and done does not pulse.
REQ-020 FINISH lasts one cycle: done=1, busy=0, i1..i4=0; then IDLE.
REQ-021 pause=1 in PLAY freezes the dwell counter, step_idx and i1..i4; pause is ignored in IDLE and FINISH.
REQ-022 abort=1 in PLAY or FINISH returns to IDLE on the next edge with i1..i4=0; done shall not pulse.
REQ-023 abort has priority over pause and start; start while busy=1 is ignored.
REQ-024 All outputs shall be registered, with no combinational path from input to output.

Reset
REQ-025 While reset=0, the FSM is IDLE, dwell counter=0, step_idx=0 and i1..i4, busy and done are 0, regardless of clk.
REQ-026 Reset asserted mid-playback aborts playback without a done pulse; after release, a new start is required.

Structure
REQ-027 The shared package holds the state enumeration, NUM_STEPS, and the constant step table.
REQ-028 Step-table vectors {i1,i2,i3,i4}: 0010, 1001, 1000, 0010, 0110, 1000, 1001, 1000, 0001, 0011, 1010, 1000.
REQ-029 Step-table dwells in cycles: 2, 5, 2, 4, 5, 5, 5, 3, 3, 2, 2, 3.
REQ-030 One sub-module, dwell_counter, implements the loadable down-counter: inputs load, value and hold; output expire.

Verification
REQ-031 Nominal run: start pulse -> i1..i4=0010 for 2 cycles, then 1001 for 5, and so on; done pulses exactly 41 cycles after the first stimulus cycle; then busy=0.
REQ-032 Detector chain: sequencer output drives the downstream sequence detector -> detector reaches its final state within one cycle of done.
REQ-033 Pause for 7 cycles mid-step 4 -> vector 0110 is held 5+7 cycles in total; all later timing shifts by 7.
REQ-034 Abort during step 6 -> next cycle i1..i4=0, busy=0 and no done; a later start replays from step 0.
REQ-035 Async reset at step 3, asserted between clock edges -> outputs clear immediately; start plus abort in the same cycle in IDLE -> remains IDLE.
REQ-036 LOOP=1 -> the step after step 11 is step 0 with no gap cycle; done never asserts; start during playback is ignored.
